// File: rtl/rv32_e_mc_scheduler.sv
// rv32_e_mc_scheduler: issue control, int/FP pending-destination scoreboard and
// shared writeback arbitration for the divider (unit 0) and the FPU (unit 1).
// Optional feature macro: RV32_MC_WATCHDOG_EN (per-unit RUN watchdog).
module rv32_e_mc_scheduler #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        issue_valid_i,
   input  logic        issue_unit_i,
   input  logic [4:0]  issue_rd_i,
   input  logic        issue_rd_fp_i,
   input  logic [14:0] src_rs_i,
   input  logic [2:0]  src_fp_i,
   input  logic [2:0]  src_used_i,
   output logic        issue_ready_o,
   output logic        stall_o,
   output logic        div_start_o,
   output logic        fpu_start_o,
   input  logic        div_done_i,
   input  logic        fpu_done_i,
   output logic        div_ack_o,
   output logic        fpu_ack_o,
   input  logic        wb_ready_i,
   output logic        wb_valid_o,
   output logic        wb_sel_o,
   output logic [4:0]  wb_rd_o,
   output logic        wb_fp_o,
   output logic        timeout_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_e;

   if (2**CNT_W <= TIMEOUT_CYCLES) begin : g_cfg_chk
      $error("CNT_W too narrow for TIMEOUT_CYCLES");
   end

   state_e      state_q [2];
   state_e      state_d [2];
   logic [4:0]  rd_q [2];
   logic [4:0]  rd_d [2];
   logic        fp_q [2];
   logic        fp_d [2];
   logic [31:0] sb_int_q, sb_int_d, sb_fp_q, sb_fp_d;
   logic        rr_q, rr_d;
   logic [1:0]  done_in, cand, grant, tmo;
   logic        hz, accept;

   // x0 is hardwired zero, so it is never tracked; f0 is an ordinary register
   function automatic logic sb_hit(logic fp, logic [4:0] r, logic [31:0] si, logic [31:0] sf);
      return fp ? sf[r] : ((r != 5'd0) && si[r]);
   endfunction

   assign done_in = {fpu_done_i, div_done_i};

   // RAW on any used source, WAW on the offered destination
   always_comb begin
      hz = 1'b0;
      for (int s = 0; s < 3; s++)
         if (src_used_i[s] && sb_hit(src_fp_i[s], src_rs_i[5*s +: 5], sb_int_q, sb_fp_q)) hz = 1'b1;
      if (issue_valid_i && sb_hit(issue_rd_fp_i, issue_rd_i, sb_int_q, sb_fp_q)) hz = 1'b1;
   end

   assign accept        = rst_ni & issue_valid_i & ~hz & (state_q[issue_unit_i] == S_IDLE);
   assign issue_ready_o = accept;
   assign stall_o       = rst_ni & hz;
   assign div_start_o   = rst_ni & (state_q[0] == S_LAUNCH);
   assign fpu_start_o   = rst_ni & (state_q[1] == S_LAUNCH);

   // writeback grant; the pointer only moves when both units contend
   always_comb begin
      grant = 2'b00;
      for (int u = 0; u < 2; u++) cand[u] = rst_ni && (state_q[u] == S_DONE) && done_in[u];
      if (wb_ready_i) grant = (cand == 2'b11) ? (rr_q ? 2'b10 : 2'b01) : cand;
   end

   assign wb_valid_o = |grant;
   assign wb_sel_o   = grant[1];
   assign wb_rd_o    = grant[1] ? rd_q[1] : (grant[0] ? rd_q[0] : 5'd0);
   assign wb_fp_o    = grant[1] ? fp_q[1] : (grant[0] & fp_q[0]);
   assign div_ack_o  = grant[0];
   assign fpu_ack_o  = grant[1];

`ifdef RV32_MC_WATCHDOG_EN
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic             err_q, err_d;

   // RUN-cycle counters; the 64th RUN cycle without done_i abandons the op
   always_comb begin
      for (int u = 0; u < 2; u++) begin
         cnt_d[u] = cnt_q[u];
         tmo[u]   = 1'b0;
         if (state_q[u] == S_LAUNCH) cnt_d[u] = '0;
         if (state_q[u] == S_RUN) begin
            cnt_d[u] = cnt_q[u] + 1'b1;
            tmo[u]   = !done_in[u] && (cnt_q[u] == CNT_W'(TIMEOUT_CYCLES - 1));
         end
      end
      err_d = err_q | (|tmo);
   end

   // watchdog state, error is sticky until reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int u = 0; u < 2; u++) cnt_q[u] <= '0;
         err_q <= 1'b0;
      end else begin
         for (int u = 0; u < 2; u++) cnt_q[u] <= cnt_d[u];
         err_q <= err_d;
      end
   end

   assign timeout_err_o = rst_ni & err_q;
`else
   assign tmo           = 2'b00;
   assign timeout_err_o = 1'b0;
`endif

   // unit FSMs, scoreboard set/clear and round-robin pointer
   always_comb begin
      sb_int_d = sb_int_q;
      sb_fp_d  = sb_fp_q;
      rr_d     = rr_q;
      for (int u = 0; u < 2; u++) begin
         state_d[u] = state_q[u];
         rd_d[u]    = rd_q[u];
         fp_d[u]    = fp_q[u];
         case (state_q[u])
            S_IDLE:   if (accept && (issue_unit_i == 1'(u))) begin
                         state_d[u] = S_LAUNCH;
                         rd_d[u]    = issue_rd_i;
                         fp_d[u]    = issue_rd_fp_i;
                      end
            S_LAUNCH: state_d[u] = S_RUN;
            S_RUN:    if (done_in[u]) state_d[u] = S_DONE;
                      else if (tmo[u]) state_d[u] = S_IDLE;
            S_DONE:   if (grant[u]) state_d[u] = S_IDLE;
            default:  state_d[u] = S_IDLE;
         endcase
         if (grant[u] || tmo[u]) begin
            if (fp_q[u]) sb_fp_d[rd_q[u]]  = 1'b0;
            else         sb_int_d[rd_q[u]] = 1'b0;
         end
      end
      if (accept) begin
         if (issue_rd_fp_i)            sb_fp_d[issue_rd_i]  = 1'b1;
         else if (issue_rd_i != 5'd0)  sb_int_d[issue_rd_i] = 1'b1;
      end
      if (wb_ready_i && (cand == 2'b11)) rr_d = ~rr_q;
   end

   // state registers, synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int u = 0; u < 2; u++) begin
            state_q[u] <= S_IDLE;
            rd_q[u]    <= 5'd0;
            fp_q[u]    <= 1'b0;
         end
         sb_int_q <= '0;
         sb_fp_q  <= '0;
         rr_q     <= 1'b0;
      end else begin
         for (int u = 0; u < 2; u++) begin
            state_q[u] <= state_d[u];
            rd_q[u]    <= rd_d[u];
            fp_q[u]    <= fp_d[u];
         end
         sb_int_q <= sb_int_d;
         sb_fp_q  <= sb_fp_d;
         rr_q     <= rr_d;
      end
   end

endmodule

// File: tb/tb_rv32_e_mc_scheduler.sv
// Bench for rv32_e_mc_scheduler: directed sequences, a hazard vector table and
// random traffic, all compared against a timestamp-based reference model.
module tb_rv32_e_mc_scheduler;

   localparam int TMO = 64;
`ifdef RV32_MC_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        issue_valid_i, issue_unit_i, issue_rd_fp_i;
   logic [4:0]  issue_rd_i;
   logic [14:0] src_rs_i;
   logic [2:0]  src_fp_i, src_used_i;
   logic        issue_ready_o, stall_o, div_start_o, fpu_start_o;
   logic        div_done_i, fpu_done_i, div_ack_o, fpu_ack_o;
   logic        wb_ready_i, wb_valid_o, wb_sel_o, wb_fp_o, timeout_err_o;
   logic [4:0]  wb_rd_o;

   always #5 clk_i = ~clk_i;

   rv32_e_mc_scheduler #(.TIMEOUT_CYCLES(TMO), .CNT_W(7)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .issue_valid_i(issue_valid_i), .issue_unit_i(issue_unit_i), .issue_rd_i(issue_rd_i),
      .issue_rd_fp_i(issue_rd_fp_i), .src_rs_i(src_rs_i), .src_fp_i(src_fp_i),
      .src_used_i(src_used_i), .issue_ready_o(issue_ready_o), .stall_o(stall_o),
      .div_start_o(div_start_o), .fpu_start_o(fpu_start_o),
      .div_done_i(div_done_i), .fpu_done_i(fpu_done_i),
      .div_ack_o(div_ack_o), .fpu_ack_o(fpu_ack_o), .wb_ready_i(wb_ready_i),
      .wb_valid_o(wb_valid_o), .wb_sel_o(wb_sel_o), .wb_rd_o(wb_rd_o), .wb_fp_o(wb_fp_o),
      .timeout_err_o(timeout_err_o)
   );

   int checks = 0;
   int errors = 0;

   // reference model: pending register set plus per-unit op record with timestamps
   bit       pend [64];
   bit       busy [2];
   int       acc [2];
   bit       seen [2];
   bit [4:0] mrd [2];
   bit       mfp [2];
   bit       ptr;
   bit       err_m;
   int       cyc = 0;
   int       g;
   bit       both;
   logic     e_ready, e_stall, e_wbv, e_sel, e_fp, e_err;
   logic [1:0] e_start, e_ack;
   logic [4:0] e_rd;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit hz(bit fp, bit [4:0] r);
      return pend[{fp, r}] && !(fp == 1'b0 && r == 5'd0);
   endfunction

   function automatic void model_eval();
      bit c [2];
      bit dn [2];
      dn[0] = div_done_i; dn[1] = fpu_done_i;
      e_stall = 1'b0;
      for (int s = 0; s < 3; s++)
         if (src_used_i[s] && hz(src_fp_i[s], src_rs_i[5*s +: 5])) e_stall = 1'b1;
      if (issue_valid_i && hz(issue_rd_fp_i, issue_rd_i)) e_stall = 1'b1;
      e_ready = issue_valid_i && !busy[issue_unit_i] && !e_stall;
      for (int u = 0; u < 2; u++) begin
         c[u] = busy[u] && seen[u] && dn[u];
         e_start[u] = busy[u] && (cyc == acc[u] + 1);
      end
      g = -1;
      both = c[0] && c[1];
      if (wb_ready_i) begin
         if (both) g = int'(ptr);
         else if (c[0]) g = 0;
         else if (c[1]) g = 1;
      end
      e_wbv = (g >= 0);
      e_sel = (g == 1);
      e_rd  = e_wbv ? mrd[g] : 5'd0;
      e_fp  = e_wbv ? mfp[g] : 1'b0;
      e_ack = {g == 1, g == 0};
      e_err = err_m;
      if (!rst_ni) begin
         e_stall = 0; e_ready = 0; e_start = 0; e_wbv = 0; e_ack = 0; e_err = 0; g = -1;
      end
   endfunction

   function automatic void model_update();
      bit dn [2];
      dn[0] = div_done_i; dn[1] = fpu_done_i;
      if (!rst_ni) begin
         for (int i = 0; i < 64; i++) pend[i] = 0;
         for (int u = 0; u < 2; u++) begin busy[u] = 0; seen[u] = 0; end
         ptr = 0; err_m = 0;
      end else begin
         for (int u = 0; u < 2; u++)
            if (busy[u] && !seen[u] && cyc >= acc[u] + 2) begin
               if (dn[u]) seen[u] = 1;
               else if (WD && (cyc - (acc[u] + 2) + 1 == TMO)) begin
                  busy[u] = 0; pend[{mfp[u], mrd[u]}] = 0; err_m = 1;
               end
            end
         if (g >= 0) begin
            busy[g] = 0;
            pend[{mfp[g], mrd[g]}] = 0;
            if (both) ptr = (g == 0);
         end
         if (e_ready) begin
            busy[issue_unit_i] = 1; acc[issue_unit_i] = cyc; seen[issue_unit_i] = 0;
            mrd[issue_unit_i] = issue_rd_i; mfp[issue_unit_i] = issue_rd_fp_i;
            if (!(issue_rd_fp_i == 1'b0 && issue_rd_i == 5'd0)) pend[{issue_rd_fp_i, issue_rd_i}] = 1;
         end
      end
      cyc++;
   endfunction

   task automatic settle();
      #1;
      model_eval();
      chk("issue_ready", issue_ready_o, e_ready);
      chk("stall", stall_o, e_stall);
      chk("div_start", div_start_o, e_start[0]);
      chk("fpu_start", fpu_start_o, e_start[1]);
      chk("div_ack", div_ack_o, e_ack[0]);
      chk("fpu_ack", fpu_ack_o, e_ack[1]);
      chk("wb_valid", wb_valid_o, e_wbv);
      if (e_wbv) begin
         chk("wb_sel", wb_sel_o, e_sel);
         chk("wb_rd", wb_rd_o, e_rd);
         chk("wb_fp", wb_fp_o, e_fp);
      end
      chk("timeout_err", timeout_err_o, e_err);
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_update();
      @(negedge clk_i);
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   task automatic issue(input logic v, input logic u, input logic [4:0] rd, input logic fp);
      issue_valid_i = v; issue_unit_i = u; issue_rd_i = rd; issue_rd_fp_i = fp;
   endtask

   task automatic src(input logic [14:0] rs, input logic [2:0] fp, input logic [2:0] used);
      src_rs_i = rs; src_fp_i = fp; src_used_i = used;
   endtask

   typedef struct {
      logic        valid;
      logic [4:0]  rd;
      logic        rd_fp;
      logic [14:0] rs;
      logic [2:0]  fp;
      logic [2:0]  used;
      logic        exp_stall;
   } vec_t;

   vec_t vt [9];

   initial begin
      // x8 pending in the divider (int), both units busy while the table runs
      vt[0] = '{1'b0, 5'd0, 1'b0, {5'd0, 5'd0, 5'd8}, 3'b000, 3'b001, 1'b1};
      vt[1] = '{1'b0, 5'd0, 1'b0, {5'd0, 5'd0, 5'd8}, 3'b001, 3'b001, 1'b0};
      vt[2] = '{1'b0, 5'd0, 1'b0, {5'd0, 5'd8, 5'd0}, 3'b000, 3'b010, 1'b1};
      vt[3] = '{1'b0, 5'd0, 1'b0, {5'd8, 5'd0, 5'd0}, 3'b000, 3'b100, 1'b1};
      vt[4] = '{1'b0, 5'd0, 1'b0, {5'd0, 5'd8, 5'd0}, 3'b000, 3'b001, 1'b0};
      vt[5] = '{1'b1, 5'd8, 1'b0, 15'd0,              3'b000, 3'b000, 1'b1};
      vt[6] = '{1'b0, 5'd8, 1'b0, 15'd0,              3'b000, 3'b000, 1'b0};
      vt[7] = '{1'b1, 5'd8, 1'b1, 15'd0,              3'b000, 3'b000, 1'b0};
      vt[8] = '{1'b1, 5'd0, 1'b0, 15'd0,              3'b000, 3'b001, 1'b0};

      rst_ni = 1'b0;
      issue(0, 0, 0, 0); src(0, 0, 0);
      div_done_i = 0; fpu_done_i = 0; wb_ready_i = 0;
      @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
      step();                               // outputs held at 0 under reset
      rst_ni = 1'b1;

      // div to x5: accept, start pulse, dependent stall, writeback after done
      issue(1, 0, 5, 0); settle(); chk("s1_ready", issue_ready_o, 1); tick();
      issue(0, 0, 0, 0); src({5'd0, 5'd0, 5'd5}, 3'b000, 3'b001);
      settle(); chk("s1_start", div_start_o, 1); chk("s1_stall", stall_o, 1); tick();
      repeat (9) step();
      div_done_i = 1; wb_ready_i = 1; step();
      settle(); chk("s1_wbv", wb_valid_o, 1); chk("s1_wbrd", wb_rd_o, 5);
      chk("s1_wbfp", wb_fp_o, 0); chk("s1_ack", div_ack_o, 1); tick();
      div_done_i = 0;
      settle(); chk("s1_release", stall_o, 0); tick();

      // FPU to f3, f3 reader stalls, int x3 unaffected
      src(0, 0, 0); issue(1, 1, 3, 1); settle(); chk("s2_ready", issue_ready_o, 1); tick();
      issue(1, 1, 4, 1); src({5'd3, 5'd0, 5'd0}, 3'b100, 3'b100);
      settle(); chk("s2_stall_f3", stall_o, 1); chk("s2_nready", issue_ready_o, 0); tick();
      src(0, 0, 0); issue(1, 0, 3, 0);
      settle(); chk("s2_x3_nostall", stall_o, 0); chk("s2_x3_ready", issue_ready_o, 1); tick();
      issue(0, 0, 0, 0); repeat (3) step();

      // both done together: divider first, then FPU
      div_done_i = 1; fpu_done_i = 1; wb_ready_i = 1; step();
      settle(); chk("arb1_sel", wb_sel_o, 0); chk("arb1_rd", wb_rd_o, 3); tick();
      div_done_i = 0;
      settle(); chk("arb2_sel", wb_sel_o, 1); chk("arb2_fp", wb_fp_o, 1); tick();
      fpu_done_i = 0;
      src({5'd3, 5'd0, 5'd0}, 3'b100, 3'b100); settle(); chk("s2_f3_free", stall_o, 0); tick();
      src(0, 0, 0);

      // repeat the contention: order alternates
      issue(1, 0, 6, 0); step(); issue(1, 1, 7, 1); step(); issue(0, 0, 0, 0); repeat (3) step();
      div_done_i = 1; fpu_done_i = 1; step();
      settle(); chk("arb3_sel", wb_sel_o, 1); tick();
      fpu_done_i = 0;
      settle(); chk("arb4_sel", wb_sel_o, 0); tick();
      div_done_i = 0;

      // busy divider refuses, x0 destination never hazards
      issue(1, 0, 8, 0); step(); issue(0, 0, 0, 0); step(); step();
      issue(1, 0, 9, 0); settle(); chk("s4_busy", issue_ready_o, 0); tick();
      issue(1, 1, 0, 0); settle(); chk("s4_x0_ready", issue_ready_o, 1); tick();
      issue(1, 1, 0, 0); src({5'd0, 5'd0, 5'd0}, 3'b000, 3'b001);
      settle(); chk("s4_x0_nostall", stall_o, 0); tick();

      // hazard vector table against pending x8
      for (int i = 0; i < 9; i++) begin
         issue(vt[i].valid, 0, vt[i].rd, vt[i].rd_fp); src(vt[i].rs, vt[i].fp, vt[i].used);
         settle(); chk($sformatf("vec%0d_stall", i), stall_o, vt[i].exp_stall);
         chk($sformatf("vec%0d_ready", i), issue_ready_o, 0); tick();
      end

      // reset with both units in flight
      issue(0, 0, 0, 0); src(0, 0, 0); rst_ni = 1'b0; step(); rst_ni = 1'b1;
      issue(1, 0, 5, 0); src({5'd0, 5'd0, 5'd8}, 3'b000, 3'b001);
      settle(); chk("s5_ready", issue_ready_o, 1); chk("s5_stall", stall_o, 0);
      chk("s5_wbv", wb_valid_o, 0); tick();
      issue(0, 0, 0, 0); src(0, 0, 0);

      // FPU that never finishes
      issue(1, 1, 9, 1); step(); issue(0, 0, 0, 0);
      repeat (TMO + 1) step();
      src({5'd0, 5'd0, 5'd9}, 3'b001, 3'b001);
      settle(); chk("wd_err", timeout_err_o, WD ? 1 : 0); chk("wd_f9", stall_o, WD ? 0 : 1); tick();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         issue_valid_i = ($urandom_range(0, 2) != 0);
         issue_unit_i  = 1'($urandom);
         issue_rd_i    = 5'($urandom_range(0, 7));
         issue_rd_fp_i = 1'($urandom);
         src_rs_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         src_fp_i = 3'($urandom); src_used_i = 3'($urandom);
         wb_ready_i = ($urandom_range(0, 3) != 0);
         if (!busy[0]) div_done_i = 0;
         else if (cyc >= acc[0] + 2 && $urandom_range(0, 2) == 0) div_done_i = 1;
         if (!busy[1]) fpu_done_i = 0;
         else if (cyc >= acc[1] + 2 && $urandom_range(0, 2) == 0) fpu_done_i = 1;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
